// File: rtl/instr_encoder.sv
// RV32I field-tuple encoder: range-checks the immediate, packs the word
// and writes it sequentially into a word-addressed program memory.
module instr_encoder #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_fmt,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    output logic              o_we,
    input  logic              i_mem_ack,
    output logic [31:0]       o_addr,
    output logic [31:0]       o_instr,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        WR,
        FULL
    } state_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } tuple_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    tuple_t             t;
    logic [ADDR_W:0]    count;
    logic [ADDR_W:0]    count_inc;
    logic [31:0]        instr;
    logic               err;
    logic [31:0]        word;
    logic               bad;
    logic signed [31:0] simm;

    assign simm      = t.imm;
    assign count_inc = count + ONE;

    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (t.fmt)
            3'd0: word = {t.funct7, t.rs2, t.rs1, t.funct3, t.rd, t.opcode};
            3'd1: begin
                word = {t.imm[11:0], t.rs1, t.funct3, t.rd, t.opcode};
                bad  = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            3'd2: begin
                word = {t.imm[11:5], t.rs2, t.rs1, t.funct3,
                        t.imm[4:0], t.opcode};
                bad  = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            3'd3: begin
                word = {t.imm[12], t.imm[10:5], t.rs2, t.rs1, t.funct3,
                        t.imm[4:1], t.imm[11], t.opcode};
                bad  = (simm < -32'sd4096) || (simm > 32'sd4094) || t.imm[0];
            end
            3'd4: begin
                word = {t.imm[31:12], t.rd, t.opcode};
                bad  = (t.imm[11:0] != 12'd0);
            end
            3'd5: begin
                word = {t.imm[20], t.imm[10:1], t.imm[11], t.imm[19:12],
                        t.rd, t.opcode};
                bad  = (simm < -32'sd1048576) || (simm > 32'sd1048574)
                       || t.imm[0];
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (i_clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (i_valid) state_nxt = ENC;
                ENC:  state_nxt = bad ? IDLE : WR;
                WR: begin
                    if (i_mem_ack)
                        state_nxt = (count_inc == DEPTH) ? FULL : IDLE;
                end
                FULL: state_nxt = FULL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Clear aborts any tuple in flight but leaves the last written word visible.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            t     <= '0;
            count <= '0;
            instr <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (i_clear) begin
                count <= '0;
            end else begin
                if (state == IDLE && i_valid)
                    t <= {i_fmt, i_opcode, i_funct3, i_funct7,
                          i_rd, i_rs1, i_rs2, i_imm};
                if (state == ENC) begin
                    if (bad) err   <= 1'b1;
                    else     instr <= word;
                end
                if (state == WR && i_mem_ack)
                    count <= count_inc;
            end
        end
    end

    assign o_ready = (state == IDLE);
    assign o_we    = (state == WR);
    assign o_full  = (count == DEPTH);
    assign o_addr  = BASE_ADDR + (32'(count) << 2);
    assign o_instr = instr;
    assign o_count = count;
    assign o_err   = err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, corner
// sequences (backpressure, full, clear/reset mid-write) and random tuples.
module tb_instr_encoder;

    localparam int          AW    = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk;
    logic        i_rst;
    logic        i_clear;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_fmt;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [31:0] i_imm;
    logic        o_we;
    logic        i_mem_ack;
    logic [31:0] o_addr;
    logic [31:0] o_instr;
    logic [AW:0] o_count;
    logic        o_full;
    logic        o_err;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .i_rst(i_rst), .i_clear(i_clear),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_fmt(i_fmt), .i_opcode(i_opcode), .i_funct3(i_funct3),
        .i_funct7(i_funct7), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_imm(i_imm), .o_we(o_we), .i_mem_ack(i_mem_ack),
        .o_addr(o_addr), .o_instr(o_instr), .o_count(o_count),
        .o_full(o_full), .o_err(o_err)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        bit          exp_err;
    } vec_t;

    int          n_cmp;
    int          n_bad;
    int          m_count;
    logic [31:0] m_instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit m_err(input logic [2:0] f, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (f)
            3'd0:       return 1'b0;
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3:       return (s < -4096) || (s > 4094) || (s % 2 != 0);
            3'd4:       return (imm % 4096) != 0;
            3'd5:       return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] bits(input logic [31:0] v, input int lo,
                                         input int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] m_enc(input vec_t v);
        logic [31:0] base;
        logic [31:0] im;
        im   = v.imm;
        base = 32'(v.op) | (32'(v.f3) << 12) | (32'(v.rs1) << 15);
        case (v.fmt)
            3'd0: return base | (32'(v.rd) << 7) | (32'(v.rs2) << 20)
                         | (32'(v.f7) << 25);
            3'd1: return base | (32'(v.rd) << 7) | (bits(im, 0, 12) << 20);
            3'd2: return base | (bits(im, 0, 5) << 7) | (32'(v.rs2) << 20)
                         | (bits(im, 5, 7) << 25);
            3'd3: return base | (bits(im, 11, 1) << 7) | (bits(im, 1, 4) << 8)
                         | (32'(v.rs2) << 20) | (bits(im, 5, 6) << 25)
                         | (bits(im, 12, 1) << 31);
            3'd4: return 32'(v.op) | (32'(v.rd) << 7) | (bits(im, 12, 20) << 12);
            3'd5: return 32'(v.op) | (32'(v.rd) << 7) | (bits(im, 12, 8) << 12)
                         | (bits(im, 11, 1) << 20) | (bits(im, 1, 10) << 21)
                         | (bits(im, 20, 1) << 31);
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input vec_t v, output bit ok);
        int w;
        w  = 0;
        ok = 1'b0;
        while (!o_ready && w < 20) begin
            tick();
            w++;
        end
        if (!o_ready) begin
            chk("ready_timeout", 32'(o_ready), 32'd1);
            return;
        end
        i_fmt = v.fmt; i_opcode = v.op; i_funct3 = v.f3; i_funct7 = v.f7;
        i_rd = v.rd; i_rs1 = v.rs1; i_rs2 = v.rs2; i_imm = v.imm;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_imm   = $urandom;
        chk("enc_ready", 32'(o_ready), 32'd0);
        chk("enc_we", 32'(o_we), 32'd0);
        tick();
        if (v.exp_err) begin
            chk("err_pulse", 32'(o_err), 32'd1);
            chk("err_we", 32'(o_we), 32'd0);
            chk("err_ready", 32'(o_ready), 32'd1);
            chk("err_instr", o_instr, m_instr);
            chk("err_count", 32'(o_count), 32'(m_count));
            tick();
            chk("err_width", 32'(o_err), 32'd0);
        end else begin
            chk("wr_we", 32'(o_we), 32'd1);
            chk("wr_err", 32'(o_err), 32'd0);
            chk("wr_instr", o_instr, v.exp_instr);
            chk("wr_addr", o_addr, BASE + 32'(4 * m_count));
            m_instr = v.exp_instr;
            ok      = 1'b1;
        end
    endtask

    task automatic ack_wr(input int hold);
        repeat (hold) begin
            tick();
            chk("bp_we", 32'(o_we), 32'd1);
            chk("bp_addr", o_addr, BASE + 32'(4 * m_count));
            chk("bp_instr", o_instr, m_instr);
            chk("bp_count", 32'(o_count), 32'(m_count));
        end
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        m_count++;
        chk("ack_count", 32'(o_count), 32'(m_count));
        chk("ack_we", 32'(o_we), 32'd0);
        chk("ack_full", 32'(o_full), 32'(m_count == DEPTH));
        chk("ack_ready", 32'(o_ready), 32'(m_count != DEPTH));
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        m_count = 0;
        chk("clr_count", 32'(o_count), 32'd0);
        chk("clr_addr", o_addr, BASE);
        chk("clr_ready", 32'(o_ready), 32'd1);
        chk("clr_full", 32'(o_full), 32'd0);
        chk("clr_we", 32'(o_we), 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic [31:0] ei, input bit ee);
        vec_t v;
        v.fmt = f; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.exp_instr = ei; v.exp_err = ee;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        int   bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096,
                          -4098, 1048574, 1048576, -1048576, -1048578};
        v.fmt = 3'($urandom_range(0, 7));
        v.op  = 7'($urandom); v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        v.rd  = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       v.imm = 32'(int'($urandom_range(0, 10000)) - 5000);
            1:       v.imm = $urandom;
            2:       v.imm = 32'(bnd[$urandom_range(0, 11)]);
            default: v.imm = $urandom & 32'hFFFF_F000;
        endcase
        v.exp_err   = m_err(v.fmt, v.imm);
        v.exp_instr = m_enc(v);
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        bit   ok;
        vec_t v;
        n_cmp = 0; n_bad = 0; m_count = 0; m_instr = '0;
        i_rst = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_mem_ack = 1'b0;
        i_fmt = '0; i_opcode = '0; i_funct3 = '0; i_funct7 = '0;
        i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0;

        tbl[0] = mk(0, 7'h33, 0, 0, 3, 1, 2, 0, 32'h002081B3, 0);
        tbl[1] = mk(1, 7'h13, 0, 0, 1, 0, 0, 5, 32'h00500093, 0);
        tbl[2] = mk(2, 7'h23, 2, 0, 0, 1, 2, 8, 32'h0020A423, 0);
        tbl[3] = mk(3, 7'h63, 0, 0, 0, 1, 2, -4, 32'hFE208EE3, 0);
        tbl[4] = mk(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345000, 32'h123452B7, 0);
        tbl[5] = mk(5, 7'h6F, 0, 0, 1, 0, 0, 2048, 32'h001000EF, 0);
        tbl[6] = mk(1, 7'h13, 0, 0, 1, 0, 0, 2048, 32'h0, 1);
        tbl[7] = mk(3, 7'h63, 0, 0, 0, 1, 2, 3, 32'h0, 1);
        tbl[8] = mk(7, 7'h33, 0, 0, 1, 1, 1, 0, 32'h0, 1);

        tick();
        tick();
        @(negedge clk);
        i_rst = 1'b1;
        tick();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_addr", o_addr, BASE);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);

        foreach (tbl[i]) begin
            if (m_count == DEPTH) do_clear();
            issue(tbl[i], ok);
            if (ok) ack_wr(0);
        end

        do_clear();
        issue(tbl[0], ok);
        if (ok) ack_wr(5);

        while (m_count < DEPTH) begin
            issue(tbl[1], ok);
            if (ok) ack_wr($urandom_range(0, 2));
            else break;
        end
        i_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("full_flag", 32'(o_full), 32'd1);
            chk("full_ready", 32'(o_ready), 32'd0);
            chk("full_we", 32'(o_we), 32'd0);
            chk("full_count", 32'(o_count), 32'(DEPTH));
        end
        i_valid = 1'b0;
        do_clear();

        issue(tbl[2], ok);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        m_count = 0;
        chk("wrclr_we", 32'(o_we), 32'd0);
        chk("wrclr_count", 32'(o_count), 32'd0);
        chk("wrclr_instr", o_instr, m_instr);
        issue(tbl[3], ok);
        if (ok) ack_wr(0);

        issue(tbl[4], ok);
        i_mem_ack = 1'b1;
        i_rst     = 1'b0;
        #1;
        i_mem_ack = 1'b0;
        m_count = 0;
        m_instr = '0;
        chk("wrrst_we", 32'(o_we), 32'd0);
        chk("wrrst_count", 32'(o_count), 32'd0);
        chk("wrrst_instr", o_instr, 32'd0);
        @(negedge clk);
        i_rst = 1'b1;
        tick();
        issue(tbl[5], ok);
        if (ok) ack_wr(1);

        for (int k = 0; k < 60; k++) begin
            if (m_count == DEPTH) do_clear();
            v = rnd_vec();
            issue(v, ok);
            if (ok) ack_wr($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes RISC-V RV32I instruction fields into 32-bit instruction words and writes them sequentially into instruction memory. It is the write-side counterpart of the IR/decoder stage: a program loader or self-test source hands it field tuples (format, opcode, funct3/7, registers, immediate) over a valid/ready handshake. It range-checks the immediate, packs the word, and issues a held write with acknowledge to a word-addressed program memory.

## Interface
- ADDR_W, 8: log2 of instruction-memory depth in words (DEPTH = 2^ADDR_W).
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.

- clk  in  1  rising-edge clock
- i_rst  in  1  asynchronous, active-low reset
- i_clear  in  1  synchronous restart: abort, counter to 0
- i_valid  in  1  field tuple valid
- o_ready  out  1  encoder can accept a tuple
- i_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6–7 illegal
- i_opcode  in  7, i_funct3 in 3, i_funct7 in 7, i_rd/i_rs1/i_rs2 in 5 each  instruction fields
- i_imm  in  32  signed byte immediate (U: full 32-bit value)
- o_we  out  1  memory write request, held until acknowledged
- i_mem_ack  in  1  memory accepted write this cycle
- o_addr  out  32  byte address = BASE_ADDR + 4*count
- o_instr  out  32  encoded word
- o_count  out  ADDR_W+1  words written since reset/clear
- o_full  out  1  count == DEPTH
- o_err  out  1  one-cycle pulse: tuple rejected

## Operation
- FSM states: IDLE, ENC, WR, FULL. Reset state is IDLE.
- IDLE: o_ready=1. When i_valid=1, all inputs are latched into an internal register and the FSM moves to ENC.
- ENC: o_ready=0. The word is built from the latched fields and registered into o_instr. The tuple is also checked:
  - fmt > 5 → error
  - I/S: imm outside [-2048, 2047] → error
  - B: imm outside [-4096, 4094] or imm[0]=1 → error
  - J: imm outside [-1048576, 1048574] or imm[0]=1 → error
  - U: imm[11:0] ≠ 0 → error
  - R: i_imm ignored
- ENC transitions: on error, o_err pulses, o_instr is left unchanged, and the FSM returns to IDLE. Otherwise it moves to WR.
- Packing, MSB→LSB:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Fields not used by a format are ignored.
- WR: o_we=1, and o_addr/o_instr are held stable. On i_mem_ack=1 at the clock edge, count increments. The FSM then goes to FULL if the new count == DEPTH, else to IDLE.
- FULL: o_ready=0 and o_full=1. The FSM stays here until i_clear.
- i_clear has priority in every state. Next cycle: IDLE, count=0, o_we=0, o_err=0. A tuple in flight is dropped; o_instr keeps its value.
- o_addr is combinational from count, with 32-bit wrap.

## Timing
- Reset values: o_ready=1, o_we=0, o_addr=BASE_ADDR, o_instr=0, o_count=0, o_full=0, o_err=0, state=IDLE.
- Reset is asynchronous mid-write: o_we drops immediately and no partial count update occurs.
- Tuple accepted at edge N (ENC during cycle N+1). At edge N+1 the FSM enters WR or IDLE, so o_we (or the o_err pulse) is high from cycle N+2.
- Zero-wait ack: i_mem_ack high in the first WR cycle → o_ready high again in cycle N+3. Throughput is one word per 3 cycles.
- i_mem_ack outside WR is ignored. i_valid outside IDLE is ignored; the source must hold the tuple until it sees o_ready&i_valid.
- o_err is exactly one cycle wide, coincident with the return to IDLE. Count is unchanged.

## Test plan
- Reset, then R add x3,x1,x2 (opcode 0x33, f3 0, f7 0): o_we at cycle N+2, o_instr=0x002081B3, o_addr=BASE_ADDR; ack → o_count=1.
- Sequence I addi x1,x0,5; S sw x2,8(x1); B beq x1,x2,-4; U lui x5 imm 0x12345000; J jal x1,2048:
  - o_instr = 0x00500093, 0x0020A423, 0xFE208EE3, 0x123452B7, 0x001000EF
  - o_addr steps by 4
- Errors: I with imm 2048; B with imm 3; fmt 7:
  - each gives a single o_err pulse and no o_we
  - o_count unchanged, o_ready back to 1
- Backpressure: hold i_mem_ack low for 5 WR cycles → o_we, o_addr and o_instr stay constant; count increments once, on the ack edge.
- ADDR_W=2: after 4 acked writes, o_full=1 and o_ready=0; i_valid is ignored. i_clear → o_count=0, o_addr=BASE_ADDR, o_ready=1.
- Assert i_clear in WR, and separately pulse i_rst low in WR: o_we drops, count=0, and the next tuple is written at BASE_ADDR.
